// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, the instruction memory and the decode stage.
// The master side is the fetch stage itself; the slave side is its environment.
interface fetch_stage_if #(
   parameter int unsigned PC_W = 9
);
   logic                stall_i;
   logic                redirect_i;
   logic [PC_W-1:0]     redirect_pc_i;
   logic                imem_en_o;
   logic [PC_W-3:0]     imem_addr_o;
   logic [31:0]         imem_rdata_i;
   logic [PC_W+31:0]    if_o;
   logic                if_valid_o;

   modport master (
      input  stall_i,
      input  redirect_i,
      input  redirect_pc_i,
      input  imem_rdata_i,
      output imem_en_o,
      output imem_addr_o,
      output if_o,
      output if_valid_o
   );

   modport slave (
      output stall_i,
      output redirect_i,
      output redirect_pc_i,
      output imem_rdata_i,
      input  imem_en_o,
      input  imem_addr_o,
      input  if_o,
      input  if_valid_o
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and produces the IF/ID register {pc_next, instr}.
// A response arriving while stalled is parked in a one-word hold buffer.
module fetch_stage #(
   parameter int unsigned      PC_W     = 9,
   parameter logic [PC_W-1:0]  RESET_PC = '0,
   parameter logic [31:0]      NOP      = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   fetch_stage_if.master   bus
);

   typedef struct packed {
      logic [PC_W-1:0] pc_next;
      logic [31:0]     instr;
   } if_reg_t;

   localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
   localparam logic [PC_W-1:0] WORD_MSK = ~PC_W'(3);
   localparam if_reg_t         BUBBLE   = '{pc_next: '0, instr: NOP};

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] f_pc_q;
   logic            f_valid_q;
   logic [31:0]     hold_q;
   logic            hold_valid_q;
   if_reg_t         if_q;
   logic            if_valid_q;
   logic [31:0]     src;

   // Memory request, response selection and output drive
   always_comb begin
      src             = hold_valid_q ? hold_q : bus.imem_rdata_i;
      bus.imem_en_o   = !rst && !bus.stall_i && !bus.redirect_i;
      bus.imem_addr_o = pc_q[PC_W-1:2];
      bus.if_o        = if_q;
      bus.if_valid_o  = if_valid_q;
   end

   // PC, in-flight tracking, hold buffer and IF/ID register; rst > redirect > stall
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         f_pc_q       <= '0;
         f_valid_q    <= 1'b0;
         hold_valid_q <= 1'b0;
         if_q         <= BUBBLE;
         if_valid_q   <= 1'b0;
      end else if (bus.redirect_i) begin
         pc_q         <= bus.redirect_pc_i & WORD_MSK;
         f_valid_q    <= 1'b0;
         hold_valid_q <= 1'b0;
         if_q         <= BUBBLE;
         if_valid_q   <= 1'b0;
      end else if (bus.stall_i) begin
         // Only the first stalled response is real; later cycles issue nothing.
         if (f_valid_q && !hold_valid_q) begin
            hold_q       <= bus.imem_rdata_i;
            hold_valid_q <= 1'b1;
         end
      end else begin
         if (f_valid_q) begin
            if_q <= '{pc_next: f_pc_q + PC_STEP, instr: src};
         end else begin
            if_q <= BUBBLE;
         end
         if_valid_q   <= f_valid_q;
         f_pc_q       <= pc_q;
         f_valid_q    <= 1'b1;
         pc_q         <= pc_q + PC_STEP;
         hold_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a stream-level reference model
// (next expected instruction address plus pending-bubble count) is checked
// every cycle, with literal expectations for the directed scenarios.
module tb_fetch_stage;

   localparam logic [31:0] NOP_I  = 32'h0000_0013;
   localparam logic [40:0] BUBBLE = {9'h000, 32'h0000_0013};

   logic clk;
   logic rst;

   fetch_stage_if #(.PC_W(9)) bus ();

   fetch_stage #(
      .PC_W     (9),
      .RESET_PC (9'h000),
      .NOP      (NOP_I)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [128];
   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit          m_live  = 1'b0;
   logic [8:0]  exp_pc  = '0;
   int          pend    = 0;
   logic        m_valid = 1'b0;
   logic [40:0] m_out   = '0;

   // previous-cycle request, for the memory model
   logic        prev_en   = 1'b0;
   logic [6:0]  prev_addr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Synchronous memory: data for last cycle's enabled address, garbage otherwise
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
      bus.imem_rdata_i = 32'hDEAD_BEEF;
      forever begin
         @(posedge clk);
         #1;
         bus.imem_rdata_i = prev_en ? mem[prev_addr] : 32'hDEAD_BEEF;
      end
   end

   // Reference model: instruction stream with a bubble count after reset/redirect
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_out   = BUBBLE;
            exp_pc  = 9'h000;
            pend    = 1;
         end else if (!m_live) begin
            m_valid = 1'b0;
         end else if (bus.redirect_i) begin
            m_valid = 1'b0;
            m_out   = BUBBLE;
            exp_pc  = bus.redirect_pc_i & 9'h1FC;
            pend    = 1;
         end else if (bus.stall_i) begin
            m_valid = m_valid;
         end else if (pend > 0) begin
            pend    = pend - 1;
            m_valid = 1'b0;
            m_out   = BUBBLE;
         end else begin
            m_valid = 1'b1;
            m_out   = {exp_pc + 9'd4, mem[exp_pc[8:2]]};
            exp_pc  = exp_pc + 9'd4;
         end
      end
   end

   // Compare process: every cycle once reset has been applied
   initial begin
      logic [8:0] issue;
      forever begin
         @(negedge clk);
         if (m_live) begin
            issue = exp_pc + ((pend > 0) ? 9'd0 : 9'd4);
            check("if_valid", 64'(bus.if_valid_o), 64'(m_valid));
            check("if_o", 64'(bus.if_o), 64'(m_out));
            check("imem_en", 64'(bus.imem_en_o),
                  64'(!rst && !bus.stall_i && !bus.redirect_i));
            check("imem_addr", 64'(bus.imem_addr_o), 64'(issue[8:2]));
         end
         prev_en   = bus.imem_en_o;
         prev_addr = bus.imem_addr_o;
      end
   end

   task automatic step(input logic r, input logic rd, input logic [8:0] rpc, input logic st);
      @(posedge clk);
      #2;
      rst               = r;
      bus.redirect_i    = rd;
      bus.redirect_pc_i = rpc;
      bus.stall_i       = st;
   endtask

   task automatic lit(input string name, input logic v, input logic [40:0] o);
      @(negedge clk);
      check({name, "_valid"}, 64'(bus.if_valid_o), 64'(v));
      check({name, "_if"}, 64'(bus.if_o), 64'(o));
   endtask

   task automatic lit_addr(input string name, input logic [6:0] a);
      @(negedge clk);
      check(name, 64'(bus.imem_addr_o), 64'(a));
   endtask

   initial begin
      rst               = 1'b1;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      bus.stall_i       = 1'b0;

      // scenario 1: reset release, first fetches
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);  lit_addr("s1_addr0", 7'd0);          // cycle 0
      step(0, 0, 0, 0);  lit("s1_c1", 0, BUBBLE);              // cycle 1
      step(0, 0, 0, 0);  lit("s1_c2", 1, {9'h004, 32'h1000_0000});
      step(0, 0, 0, 0);  lit("s1_c3", 1, {9'h008, 32'h1000_0001});
      // scenario 2: 3-cycle stall while if_o = {00C, mem[2]}
      step(0, 0, 0, 1);  lit("s2_c4", 1, {9'h00C, 32'h1000_0002});
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);  lit("s2_c6", 1, {9'h00C, 32'h1000_0002});
      step(0, 0, 0, 0);  lit("s2_c7", 1, {9'h00C, 32'h1000_0002});
      step(0, 0, 0, 0);  lit("s2_c8", 1, {9'h010, 32'h1000_0003});
      step(0, 0, 0, 0);  lit("s2_c9", 1, {9'h014, 32'h1000_0004});
      // scenario 3: redirect to 0x043
      step(0, 1, 9'h043, 0);
      step(0, 0, 0, 0);  lit("s3_t1", 0, BUBBLE);
      check("s3_addr", 64'(bus.imem_addr_o), 64'd16);
      step(0, 0, 0, 0);  lit("s3_t2", 0, BUBBLE);
      step(0, 0, 0, 0);  lit("s3_t3", 1, {9'h044, 32'h1000_0010});
      // scenario 4: redirect with stall, stall held 2 more cycles
      step(0, 1, 9'h080, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);  lit("s4_b1", 0, BUBBLE);
      step(0, 0, 0, 0);  lit("s4_b2", 0, BUBBLE);
      step(0, 0, 0, 0);  lit("s4_v", 1, {9'h084, 32'h1000_0020});
      // scenario 5: PC wrap
      step(0, 1, 9'h1F8, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);  lit("s5_a", 1, {9'h1FC, 32'h1000_007E});
      step(0, 0, 0, 0);  lit("s5_b", 1, {9'h000, 32'h1000_007F});
      step(0, 0, 0, 0);  lit("s5_c", 1, {9'h004, 32'h1000_0000});
      // scenario 6: stall with hold captured, then reset
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);  lit("s6_c0", 0, BUBBLE);
      check("s6_addr", 64'(bus.imem_addr_o), 64'd0);
      step(0, 0, 0, 0);  lit("s6_c1", 0, BUBBLE);
      step(0, 0, 0, 0);  lit("s6_c2", 1, {9'h004, 32'h1000_0000});

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(logic'($urandom_range(0, 99) == 0),
              logic'($urandom_range(0, 9) == 0),
              9'($urandom),
              logic'($urandom_range(0, 3) == 0));
      end
      step(0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline: owns the 9-bit PC, issues word reads to the synchronous instruction memory and produces the IF/ID pipeline register (`if_reg`: `pc_next`, `instr`) consumed by the decode stage. It honours stall requests from the hazard unit and PC redirects from taken branches and jumps. While stalled it buffers the in-flight memory response so that no instruction is lost or duplicated.

## Interface
Parameters:
- `PC_W`, 9: PC width in bits (byte address).
- `RESET_PC`, 9'h000: PC loaded on reset.
- `NOP`, 32'h0000_0013: bubble instruction, `addi x0,x0,0`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_i`  in  1  hold PC and IF/ID (load-use hazard).
- `redirect_i`  in  1  taken branch/jump; flush the stage.
- `redirect_pc_i`  in  9  target byte address; bits [1:0] are ignored and forced to 0.
- `imem_en_o`  out  1  memory read enable.
- `imem_addr_o`  out  7  word address, equal to `pc_q[8:2]`.
- `imem_rdata_i`  in  32  data for the address issued in the previous cycle when `imem_en_o` was 1. Undefined otherwise.
- `if_o`  out  41  `reg_pkg::if_reg` {pc_next, instr}, registered.
- `if_valid_o`  out  1  `if_o` holds a real instruction (0 = bubble).

## Operation
- State:
  - `pc_q`: address being issued this cycle.
  - `f_valid_q` / `f_pc_q`: fetch in flight; its data is on `imem_rdata_i` this cycle.
  - `hold_valid_q` / `hold_q`: captured response.
  - The output register.
- Data source: `src = hold_valid_q ? hold_q : imem_rdata_i`.
- `imem_en_o = !rst && !stall_i && !redirect_i`.
- `imem_addr_o = pc_q[8:2]`.
- Priority per edge is `rst` > `redirect_i` > `stall_i` > normal.
  - **Reset:**
    - `pc_q=RESET_PC`
    - `f_valid_q=0`, `hold_valid_q=0`
    - `if_o={9'h000, NOP}`, `if_valid_o=0`
  - **Redirect (stall ignored):**
    - `pc_q = {redirect_pc_i[8:2],2'b00}`
    - `f_valid_q=0`, `hold_valid_q=0`
    - `if_o={9'h000, NOP}`, `if_valid_o=0`
  - **Stall:**
    - `pc_q`, `f_*` and `if_o`/`if_valid_o` hold.
    - If `f_valid_q && !hold_valid_q`: `hold_q <= imem_rdata_i` and `hold_valid_q <= 1`.
    - Otherwise the hold buffer is unchanged.
  - **Normal:**
    - `if_o <= {f_pc_q+4, src}` when `f_valid_q`, else `{9'h000, NOP}`.
    - `if_valid_o <= f_valid_q`.
    - `f_pc_q <= pc_q`, `f_valid_q <= 1`.
    - `pc_q <= pc_q+4`.
    - `hold_valid_q <= 0`.
- Arithmetic: all PC adds are modulo 2^9. `0x1FC+4 = 0x000` with no flag.
- `pc_next` is always the fetched instruction's PC + 4.
- Bubbles are always `{9'h000, NOP}` with `if_valid_o=0`.

## Timing
- Fetch-to-output latency is 2 cycles.
  - Address issued in cycle t; data arrives in t+1; it is registered into `if_o`/`if_valid_o` at the end of t+1 and visible in t+2.
- Reset:
  - First cycle with `rst=0` is cycle 0: `RESET_PC` is issued.
  - First valid `if_o` appears in cycle 2.
  - Outputs in cycles 0–1: `if_valid_o=0`, `if_o={0,NOP}`.
- Redirect sampled in cycle t:
  - `if_valid_o=0` in t+1 and t+2.
  - Target instruction is valid in t+3 with `pc_next = target+4`.
  - Exactly two bubbles.
- Stall of N cycles: `if_o` is frozen for N cycles. The cycle after `stall_i` falls, `if_o` advances to the next sequential instruction (taken from `hold_q` if captured).
- A stall while `f_valid_q=0` (e.g. right after a redirect) captures nothing. The bubble count then grows by N.
- Reset mid-stall with `hold_valid_q=1` discards the buffer. Reset values are visible the cycle after `rst` is sampled.

## Test plan
1. Memory model `mem[i]=32'h1000_0000+i`; `rst` high 2 cycles, then low -> cycle 2 `if_valid_o=1`, `if_o={9'h004,32'h1000_0000}`; cycle 3 `{9'h008,32'h1000_0001}`; `imem_addr_o` counts 0,1,2…
2. Assert `stall_i` for 3 cycles while `if_o={9'h00C,mem[2]}`; drive `imem_rdata_i=32'hDEAD_BEEF` whenever `imem_en_o` was 0 -> `if_o` is held 3 cycles, `imem_en_o=0`, next outputs are `{9'h010,mem[3]}` then `{9'h014,mem[4]}`, no DEADBEEF, no skip or duplicate.
3. `redirect_i=1`, `redirect_pc_i=9'h043` in cycle t -> `imem_addr_o=16` in t+1; `if_valid_o=0` with `if_o={0,NOP}` in t+1 and t+2; t+3 `{9'h044,mem[16]}`.
4. `redirect_i` and `stall_i` both high for one cycle, stall held 2 more cycles -> redirect taken (`pc_q=target`); bubbles extend by 2; first valid output is target+4 / mem[target>>2].
5. Redirect to 9'h1F8 -> valid outputs `pc_next` 9'h1FC, 9'h000, 9'h004 with mem[126], mem[127], mem[0].
6. Stall 2 cycles (hold captured), then `rst` for 1 cycle -> next cycle `if_valid_o=0`, `if_o={0,NOP}`, `imem_addr_o=0`; restart matches scenario 1 timing and the stale held word never appears.
